// File: rtl/rr_sel_arbiter4_pkg.sv
// Types and constants shared by the rr_sel_arbiter4 block.
//   state_t : two-state FSM encoding (IDLE: no grant, BUSY: grant held)
//   CNT_W   : width of the hold counter
// Ports: none (package).
`include "rr_sel_arbiter4_defs.sv"

package rr_sel_arbiter4_pkg;

  typedef enum logic {
    IDLE = `RR_SEL_ARBITER4_IDLE,
    BUSY = `RR_SEL_ARBITER4_BUSY
  } state_t;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/rr_sel_arbiter4_defs.sv
// Shared state encodings for rr_sel_arbiter4.
// This header is included by the design package, the top module and the
// testbench, so that all of them use the same two state codes.
// Ports: none (preprocessor definitions only).
`ifndef RR_SEL_ARBITER4_DEFS_SV
`define RR_SEL_ARBITER4_DEFS_SV

`define RR_SEL_ARBITER4_IDLE 1'b0
`define RR_SEL_ARBITER4_BUSY 1'b1

`endif

// File: rtl/rr_sel_arbiter4_pick4.sv
// rr_pick4: combinational rotating-priority search over four requests.
// The winner is the first set bit of req when scanning ptr, ptr+1, ptr+2,
// ptr+3 (modulo 4).
// Ports:
//   req[3:0] : per-channel request bits
//   ptr[1:0] : channel with highest priority this cycle
//   any      : at least one request is set
//   idx[1:0] : winning channel (0 when any is low)
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from the lowest priority up to the highest so that the last hit,
  // i.e. the one nearest to ptr, is the one left in idx.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    any  = 1'b0;
    idx  = 2'd0;
    cand = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// rr_sel_arbiter4: round-robin arbiter driving the select of a 4:1 mux.
// A winner is picked in IDLE, the grant is held in BUSY until the grantee
// signals done, withdraws its request, or has held it for MAX_HOLD cycles.
// Every release is followed by one IDLE cycle before the next grant.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high reset
//   req     : per-channel requests
//   done    : grantee finished (only looked at in BUSY)
//   sel     : registered mux select, held through IDLE
//   grant   : registered one-hot grant (1<<sel while valid, else 0)
//   valid   : registered, high while sel names a granted channel
//   timeout : registered one-cycle pulse after a release caused by expiry
`include "rr_sel_arbiter4_defs.sv"

module rr_sel_arbiter4
  import rr_sel_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid,
  output logic       timeout
);

  // Counter value seen during the MAX_HOLD-th BUSY cycle (counter is 0 in
  // the first one).
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pick_any;
  logic [1:0] pick_idx;
  logic       normal_release;
  logic       hold_expired;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign normal_release = done || !req[sel_q];
  assign hold_expired   = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (pick_any) begin
          sel_d   = pick_idx;
          grant_d = 4'b0001 << pick_idx;
          valid_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (normal_release || hold_expired) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          grant_d   = 4'b0000;
          ptr_d     = sel_q + 2'd1;
          cnt_d     = '0;
          // A coinciding done or withdraw makes this an ordinary release.
          timeout_d = hold_expired && !normal_release;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Self-checking bench for rr_sel_arbiter4 (MAX_HOLD = 4).
// Each driven cycle pushes the expected registered outputs onto a queue;
// after the clock edge the entry is popped and compared with the DUT.
`include "rr_sel_arbiter4_defs.sv"

module tb_rr_sel_arbiter4;

  localparam int TB_MAX_HOLD = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];

  // Reference model state
  logic       m_busy;
  logic [1:0] m_ptr;
  logic [1:0] m_sel;
  logic       m_timeout;
  int         m_hold;

  rr_sel_arbiter4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_ptr     = 2'd0;
    m_sel     = 2'd0;
    m_timeout = 1'b0;
    m_hold    = 0;
  endtask

  // Advance the model by one clock edge with the given inputs and push the
  // outputs it predicts for the following cycle.
  task automatic model_step(input logic [3:0] r, input logic d);
    exp_t       e;
    logic       found;
    logic       norm;
    logic       expire;
    logic [1:0] c;
    m_timeout = 1'b0;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = 2'((int'(m_ptr) + k) % 4);
        if (!found && r[c]) begin
          found  = 1'b1;
          m_sel  = c;
          m_busy = 1'b1;
          m_hold = 1;
        end
      end
    end else begin
      expire = (m_hold == TB_MAX_HOLD);
      norm   = d || !r[m_sel];
      if (norm || expire) begin
        m_busy    = 1'b0;
        m_ptr     = 2'((int'(m_sel) + 1) % 4);
        m_timeout = expire && !norm;
      end else begin
        m_hold++;
      end
    end
    e.sel     = m_sel;
    e.grant   = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    e.valid   = m_busy;
    e.timeout = m_timeout;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs (called in the low clock phase), then compare
  // outputs on the following falling edge.
  task automatic cycle(input logic [3:0] r, input logic d);
    exp_t e;
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("sel", sel, e.sel);
      check("grant", grant, e.grant);
      check("valid", valid, e.valid);
      check("timeout", timeout, e.timeout);
      check("state", dut.state_q, e.valid ? `RR_SEL_ARBITER4_BUSY : `RR_SEL_ARBITER4_IDLE);
    end
    check("grant_onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
    if (valid) check("grant_eq_sel", grant, 4'b0001 << sel);
  endtask

  // Assert reset between clock edges and confirm outputs clear at once.
  task automatic async_reset();
    req   = 4'b0000;
    done  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_sel", sel, 2'd0);
    check("rst_grant", grant, 4'b0000);
    check("rst_valid", valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_seq [5];
    int         v_cnt;
    logic [3:0] r;

    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    #1;
    check("init_sel", sel, 2'd0);
    check("init_grant", grant, 4'b0000);
    check("init_valid", valid, 1'b0);
    check("init_timeout", timeout, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Basic grant, done release, pointer rotation to channel 2
    cycle(4'b0000, 1'b0);
    cycle(4'b0101, 1'b0);
    check("bas_sel0", sel, 2'd0);
    check("bas_grant0", grant, 4'b0001);
    check("bas_valid0", valid, 1'b1);
    cycle(4'b0101, 1'b0);
    cycle(4'b0101, 1'b0);
    cycle(4'b0101, 1'b1);
    check("bas_rel_valid", valid, 1'b0);
    check("bas_rel_sel_hold", sel, 2'd0);
    cycle(4'b0101, 1'b0);
    check("bas_sel2", sel, 2'd2);
    check("bas_grant2", grant, 4'b0100);

    // Withdraw, then expiry of a held grant
    cycle(4'b0000, 1'b0);
    check("wd_valid", valid, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0010, 1'b0);
    v_cnt = 0;
    while (valid && v_cnt < 10) begin
      v_cnt++;
      cycle(4'b0010, 1'b0);
    end
    check("exp_busy_cycles", v_cnt, TB_MAX_HOLD);
    check("exp_timeout", timeout, 1'b1);
    check("exp_valid", valid, 1'b0);
    cycle(4'b0010, 1'b0);
    check("exp_regrant", grant, 4'b0010);
    check("exp_timeout_clr", timeout, 1'b0);

    // done on the MAX_HOLD-th cycle: normal release
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b1);
    check("coinc_valid", valid, 1'b0);
    check("coinc_timeout", timeout, 1'b0);

    // Mid-grant withdraw advances the pointer past the withdrawn channel
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    check("wd2_valid", valid, 1'b0);
    check("wd2_timeout", timeout, 1'b0);
    cycle(4'b1111, 1'b0);
    check("wd2_next_grant", grant, 4'b1000);

    // Asynchronous reset while channel 3 is granted
    cycle(4'b1111, 1'b0);
    async_reset();

    // Full round robin from ptr=0 with one IDLE gap per grant
    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;
    for (int g = 0; g < 5; g++) begin
      cycle(4'b1111, 1'b0);
      check("rr_grant", grant, exp_seq[g]);
      cycle(4'b1111, 1'b1);
      check("rr_gap", valid, 1'b0);
    end

    // Randomised traffic against the model
    r = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cycle(r, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
